fifo_fill_ctrl: RTL and testbench

- Refill scheduler for the pixel FIFO that feeds the VGA/DVI output path of vgamult.
- Each frame, walks the frame buffer address space in bursts and issues read requests to the memory port only when the FIFO has room for a full burst.
- Writes the returned words into the FIFO.
- Sits between the frame-timing logic (frame_start) and the FIFO write side.

---
 rtl/fifo_fill_ctrl_if.sv | 30 +++
 rtl/fifo_fill_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fifo_fill_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_fill_ctrl_if.sv
// Memory read port and FIFO write/status signals of the pixel FIFO refill controller.
// master = controller side, slave = memory/FIFO side.
interface fifo_fill_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24,
    parameter int CNT_W  = 10
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_len;
    logic              mem_ack;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_rd_en;
    logic              fifo_empty;

    modport master (
        output mem_req, mem_addr, mem_len, fifo_wr_en, fifo_wr_data,
        input  mem_ack, mem_rd_valid, mem_rd_data, fifo_count, fifo_full, fifo_rd_en, fifo_empty
    );

    modport slave (
        input  mem_req, mem_addr, mem_len, fifo_wr_en, fifo_wr_data,
        output mem_ack, mem_rd_valid, mem_rd_data, fifo_count, fifo_full, fifo_rd_en, fifo_empty
    );
endinterface

// File: rtl/fifo_fill_ctrl.sv
// Pixel FIFO refill scheduler: fetches a frame in bursts, one outstanding, only when a burst fits.
// Optional underflow statistics counter enabled by defining FIFO_FILL_STATS_EN.
module fifo_fill_ctrl #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 24,
    parameter int CNT_W       = 10,
    parameter int FIFO_DEPTH  = 512,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 307200
) (
    input  logic                   clk_100mhz,
    input  logic                   rst,
    input  logic                   frame_start,
    fifo_fill_ctrl_if.master       bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overflow,
    output logic [15:0]            underflow_cnt
);
    localparam int              WL_W     = $clog2(FRAME_WORDS + 1);
    localparam logic [WL_W-1:0] FRAME_WL = WL_W'(FRAME_WORDS);
    localparam logic [7:0]      BURST_L8 = 8'(BURST_LEN);

    typedef enum logic [2:0] {IDLE, WAIT_ROOM, REQ, RECV, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [WL_W-1:0]   words_left_reg, words_left_next;
    logic [7:0]        len_reg, len_next;
    logic [7:0]        beats_reg, beats_next;
    logic              restart_pending_reg, restart_pending_next;
    logic              room_reg;
    logic              wr_en_reg, wr_en_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;
    logic              overflow_reg, overflow_next;
    logic [7:0]        cur_len;
    logic              start;

    // The last burst of a frame carries only the remainder.
    always_comb begin
        if (32'(words_left_reg) < BURST_LEN) cur_len = 8'(words_left_reg);
        else                                 cur_len = BURST_L8;
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_reg           <= IDLE;
            addr_reg            <= '0;
            words_left_reg      <= '0;
            len_reg             <= '0;
            beats_reg           <= '0;
            restart_pending_reg <= 1'b0;
            room_reg            <= 1'b0;
            wr_en_reg           <= 1'b0;
            wr_data_reg         <= '0;
            overflow_reg        <= 1'b0;
        end else begin
            state_reg           <= state_next;
            addr_reg            <= addr_next;
            words_left_reg      <= words_left_next;
            len_reg             <= len_next;
            beats_reg           <= beats_next;
            restart_pending_reg <= restart_pending_next;
            room_reg            <= (32'(bus.fifo_count) <= (FIFO_DEPTH - BURST_LEN));
            wr_en_reg           <= wr_en_next;
            wr_data_reg         <= wr_data_next;
            overflow_reg        <= overflow_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        addr_next            = addr_reg;
        words_left_next      = words_left_reg;
        len_next             = len_reg;
        beats_next           = beats_reg;
        restart_pending_next = restart_pending_reg;
        wr_en_next           = 1'b0;
        wr_data_next         = wr_data_reg;
        overflow_next        = overflow_reg;
        start                = 1'b0;

        case (state_reg)
            IDLE: begin
                if (frame_start) start = 1'b1;
            end
            WAIT_ROOM: begin
                if (frame_start)   start = 1'b1;
                else if (room_reg) state_next = REQ;
            end
            REQ: begin
                // An accepted request must be received even if a new frame is requested meanwhile.
                if (bus.mem_ack) begin
                    len_next   = cur_len;
                    beats_next = cur_len;
                    state_next = RECV;
                    if (frame_start) restart_pending_next = 1'b1;
                end else if (frame_start) begin
                    start = 1'b1;
                end
            end
            RECV: begin
                if (frame_start) restart_pending_next = 1'b1;
                if (bus.mem_rd_valid) begin
                    wr_en_next   = !bus.fifo_full;
                    wr_data_next = bus.mem_rd_data;
                    beats_next   = beats_reg - 8'd1;
                    if (bus.fifo_full) overflow_next = 1'b1;
                    if (beats_reg == 8'd1) begin
                        if (restart_pending_reg || frame_start) begin
                            start = 1'b1;
                        end else begin
                            addr_next       = addr_reg + ADDR_W'(len_reg);
                            words_left_next = words_left_reg - WL_W'(len_reg);
                            state_next      = (words_left_reg == WL_W'(len_reg)) ? DONE : WAIT_ROOM;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                if (frame_start) start = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (start) begin
            addr_next            = '0;
            words_left_next      = FRAME_WL;
            restart_pending_next = 1'b0;
            state_next           = WAIT_ROOM;
        end
    end

    assign bus.mem_req      = (state_reg == REQ);
    assign bus.mem_addr     = (state_reg == REQ) ? addr_reg : '0;
    assign bus.mem_len      = (state_reg == REQ) ? cur_len : 8'd0;
    assign bus.fifo_wr_en   = wr_en_reg;
    assign bus.fifo_wr_data = wr_data_reg;
    assign busy             = (state_reg == WAIT_ROOM) || (state_reg == REQ) || (state_reg == RECV);
    assign frame_done       = (state_reg == DONE);
    assign overflow         = overflow_reg;

`ifdef FIFO_FILL_STATS_EN
    logic [15:0] underflow_reg;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst)
            underflow_reg <= '0;
        else if (bus.fifo_rd_en && bus.fifo_empty && underflow_reg != 16'hFFFF)
            underflow_reg <= underflow_reg + 16'd1;
    end

    assign underflow_cnt = underflow_reg;
`else
    logic unused_stats;
    assign unused_stats  = bus.fifo_rd_en & bus.fifo_empty;
    assign underflow_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Directed bench for fifo_fill_ctrl with FRAME_WORDS=40, BURST_LEN=16: burst table plus corner sequences.
module tb_fifo_fill_ctrl;
    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic [15:0] underflow_cnt;

    fifo_fill_ctrl_if #(.ADDR_W(19), .DATA_W(24), .CNT_W(10)) ifc ();

    fifo_fill_ctrl #(.FRAME_WORDS(40), .BURST_LEN(16)) dut (
        .clk_100mhz    (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .bus           (ifc.master),
        .busy          (busy),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .underflow_cnt (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int new_frame;
        int addr;
        int len;
        int ack_dly;
        int full_mask;
        int fs_beat;
        int exp_done;
    } burst_vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] wr_q[$];
    logic [23:0] exp_q[$];
    logic [23:0] dval = 24'hA00000;
    logic        ovf_exp = 1'b0;

    always @(posedge clk) begin
        #1;
        if (ifc.fifo_wr_en) wr_q.push_back(ifc.fifo_wr_data);
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (ifc.mem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic compare_writes();
        int bad = 0;
        check("wr_count", wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) bad++;
        check("wr_data_order", bad, 0);
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic do_burst(input burst_vec_t v);
        bit ok;
        bit f;
        if (v.new_frame != 0) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        wait_req(ok);
        check("req_seen", ok, 1);
        if (!ok) return;
        check("mem_addr", ifc.mem_addr, v.addr);
        check("mem_len", ifc.mem_len, v.len);
        check("busy_req", busy, 1);
        repeat (v.ack_dly) @(negedge clk);
        check("req_held_addr", {ifc.mem_req, 12'd0, ifc.mem_addr}, {1'b1, 12'd0, 19'(v.addr)});
        ifc.mem_ack = 1'b1;
        @(negedge clk);
        ifc.mem_ack = 1'b0;
        check("req_drop", ifc.mem_req, 0);
        for (int b = 0; b < v.len; b++) begin
            f = v.full_mask[b];
            ifc.mem_rd_valid = 1'b1;
            ifc.mem_rd_data  = dval;
            ifc.fifo_full    = f;
            frame_start      = (b == v.fs_beat);
            if (f) ovf_exp = 1'b1;
            else   exp_q.push_back(dval);
            dval = dval + 24'd1;
            @(negedge clk);
        end
        ifc.mem_rd_valid = 1'b0;
        ifc.fifo_full    = 1'b0;
        frame_start      = 1'b0;
        check("frame_done", frame_done, v.exp_done);
        if (v.exp_done != 0) begin
            check("done_with_last_wr", ifc.fifo_wr_en, 1);
            check("busy_at_done", busy, 0);
            check("overflow", overflow, ovf_exp);
            @(negedge clk);
            check("done_one_cycle", {frame_done, busy}, 2'b00);
            compare_writes();
        end
    endtask

    burst_vec_t vecs[11];

    initial begin
        bit ok;
        int seen;

        vecs = '{
            '{0,  0, 16, 2, 'h0000, -1, 0},
            '{0, 16, 16, 2, 'h0000, -1, 0},
            '{0, 32,  8, 2, 'h0000, -1, 1},
            '{1,  0, 16, 1, 'h0070, -1, 0},
            '{0, 16, 16, 0, 'h0000, -1, 0},
            '{0, 32,  8, 3, 'h0000, -1, 1},
            '{1,  0, 16, 2, 'h0000, -1, 0},
            '{0, 16, 16, 2, 'h0000,  4, 0},
            '{0,  0, 16, 2, 'h0000, -1, 0},
            '{0, 16, 16, 0, 'h0000, -1, 0},
            '{0, 32,  8, 0, 'h0000, -1, 1}
        };

        rst              = 1'b1;
        frame_start      = 1'b0;
        ifc.mem_ack      = 1'b0;
        ifc.mem_rd_valid = 1'b0;
        ifc.mem_rd_data  = '0;
        ifc.fifo_count   = '0;
        ifc.fifo_full    = 1'b0;
        ifc.fifo_rd_en   = 1'b0;
        ifc.fifo_empty   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {ifc.mem_req, ifc.fifo_wr_en, busy, frame_done, overflow}, 5'b0);
        check("rst_addr_len", {ifc.mem_addr, ifc.mem_len}, 0);
        check("rst_underflow", underflow_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Room gating: 497 words leave no room for a 16-word burst, 496 does.
        ifc.fifo_count = 10'd497;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (ifc.mem_req) seen++;
            @(negedge clk);
        end
        check("room_block", seen, 0);
        check("busy_waiting", busy, 1);
        ifc.fifo_count = 10'd496;
        @(negedge clk);
        check("room_lat1", ifc.mem_req, 0);
        @(negedge clk);
        check("room_lat2", ifc.mem_req, 1);
        ifc.fifo_count = 10'd0;

        for (int i = 0; i < 11; i++) begin
            do_burst(vecs[i]);
            if (vecs[i].exp_done == 0 && i == 7) check("no_done_after_abort", busy, 1);
        end
        check("overflow_sticky", overflow, 1);

        // Restart while a request is pending without ack.
        do_burst('{1, 0, 16, 0, 'h0000, -1, 0});
        wait_req(ok);
        check("req2_seen", ok, 1);
        check("req2_addr", ifc.mem_addr, 16);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("restart_req_drop", ifc.mem_req, 0);
        wait_req(ok);
        check("restart_req_seen", ok, 1);
        check("restart_addr", ifc.mem_addr, 0);
        check("restart_len", ifc.mem_len, 16);

        // Reset in the middle of a burst.
        ifc.mem_ack = 1'b1;
        @(negedge clk);
        ifc.mem_ack = 1'b0;
        for (int b = 0; b < 5; b++) begin
            ifc.mem_rd_valid = 1'b1;
            ifc.mem_rd_data  = dval;
            dval = dval + 24'd1;
            @(negedge clk);
        end
        check("pre_rst_wr_en", ifc.fifo_wr_en, 1);
        ifc.mem_rd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {ifc.mem_req, ifc.fifo_wr_en, busy, frame_done, overflow}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        exp_q.delete();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_req(ok);
        check("post_rst_req", ok, 1);
        check("post_rst_addr_len", {ifc.mem_addr, ifc.mem_len}, {19'd0, 8'd16});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Read beats outside a burst must not reach the FIFO.
        for (int b = 0; b < 4; b++) begin
            ifc.mem_rd_valid = 1'b1;
            ifc.mem_rd_data  = 24'h55AA55;
            @(negedge clk);
        end
        ifc.mem_rd_valid = 1'b0;
        @(negedge clk);
        check("stray_beats_dropped", wr_q.size(), 0);

        // Underflow statistics: 7 qualifying cycles.
        ifc.fifo_rd_en = 1'b1;
        ifc.fifo_empty = 1'b1;
        repeat (7) @(negedge clk);
        ifc.fifo_empty = 1'b0;
        @(negedge clk);
        ifc.fifo_rd_en = 1'b0;
        ifc.fifo_empty = 1'b1;
        @(negedge clk);
        ifc.fifo_empty = 1'b0;
        @(negedge clk);
`ifdef FIFO_FILL_STATS_EN
        check("underflow_cnt", underflow_cnt, 7);
`else
        check("underflow_cnt", underflow_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
